// File: rtl/s1_cfg_loader.sv
// S1 cell configuration loader: collects NUM_CELLS 4-bit words into a shadow and commits them to CFG in one step.
// Optional even-parity checking with an ERROR state is enabled by defining S1_CFG_PARITY_EN.
module s1_cfg_loader #(
    parameter int NUM_CELLS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic                   START,
    input  logic [3:0]             DIN,
    input  logic                   DIN_P,
    input  logic                   DIN_VALID,
    output logic                   DIN_READY,
    output logic [4*NUM_CELLS-1:0] CFG,
    output logic [IDX_W-1:0]       CELL_IDX,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
`ifdef S1_CFG_PARITY_EN
    localparam logic [1:0] ST_ERROR  = 2'd3;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

    logic [1:0]             state;
    logic [IDX_W-1:0]       cell_idx;
    logic [4*NUM_CELLS-1:0] shadow;
    logic [4*NUM_CELLS-1:0] cfg_q;

`ifdef S1_CFG_PARITY_EN
    logic err_q;

    function automatic logic parity_ok(input logic [3:0] d, input logic p);
        return p == ^d;
    endfunction
`else
    logic unused_din_p;
    assign unused_din_p = DIN_P;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= ST_IDLE;
            cell_idx <= '0;
            shadow   <= '0;
            cfg_q    <= '0;
`ifdef S1_CFG_PARITY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state    <= ST_LOAD;
                        cell_idx <= '0;
                    end
                end
                ST_LOAD: begin
                    if (DIN_VALID) begin
`ifdef S1_CFG_PARITY_EN
                        if (!parity_ok(DIN, DIN_P)) begin
                            // Bad word is dropped; CELL_IDX keeps the count of good words
                            state <= ST_ERROR;
                            err_q <= 1'b1;
                        end else
`endif
                        begin
                            shadow[{cell_idx, 2'b00} +: 4] <= DIN;
                            cell_idx <= cell_idx + 1'b1;
                            if (cell_idx == LAST_IDX) begin
                                state <= ST_COMMIT;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    cfg_q <= shadow;
                    state <= ST_IDLE;
                end
`ifdef S1_CFG_PARITY_EN
                ST_ERROR: begin
                    if (START) begin
                        state    <= ST_LOAD;
                        cell_idx <= '0;
                        err_q    <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are registers or pure state decodes; no input reaches an output combinationally
    assign DIN_READY = (state == ST_LOAD);
    assign BUSY      = (state == ST_LOAD) || (state == ST_COMMIT);
    assign DONE      = (state == ST_COMMIT);
    assign CFG       = cfg_q;
    assign CELL_IDX  = cell_idx;
`ifdef S1_CFG_PARITY_EN
    assign ERR       = err_q;
`else
    assign ERR       = 1'b0;
`endif

endmodule
